connect_four_engine: RTL

Game-state engine that owns the Connect Four board and is its only writer. It turns conditioned button presses into cursor moves and piece drops, finds the landing row, checks for a win or draw, and hands the turn to the other player. Its outputs drive the VGA renderer, which only reads the board, cursor column, current player and winner.

---
 rtl/connect_four_pkg.sv | 14 +
 rtl/connect_four_engine_btn_edge.sv | 11 +
 rtl/connect_four_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/connect_four_pkg.sv
// connect_four_pkg: shared encodings, FSM states and board indexing for the Connect Four engine.
package connect_four_pkg;
   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1 = 2'b01;
   localparam logic [1:0] CELL_P2 = 2'b10;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_DRAW = 2'b11;
   typedef enum logic [1:0] {IDLE, DROP, CHECK, OVER} state_e;
   function automatic int cell_idx(input int r, input int c, input int cols = DEF_COLS);
      return 2 * (r * cols + c);
   endfunction
endpackage

// File: rtl/connect_four_engine_btn_edge.sv
// btn_edge: registers a level button and emits a one-cycle pulse on its rising edge.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic press
);
   logic q;
   always_ff @(posedge clk) q <= rst ? 1'b0 : level;
   assign press = level & ~q;
endmodule

// File: rtl/connect_four_engine.sv
// connect_four_engine: owns the board, moves the cursor, drops pieces and detects wins or draws.
module connect_four_engine
   import connect_four_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   move_right,
   input  logic                   move_left,
   input  logic                   drop_piece,
   output logic [ROWS*COLS*2-1:0] board_out,
   output logic [2:0]             current_col,
   output logic [1:0]             current_player,
   output logic [1:0]             winner,
   output logic                   game_over,
   output logic                   busy
);
   localparam int RW = $clog2(ROWS);
   localparam int PW = $clog2(ROWS * COLS + 1);
   state_e state;
   logic [ROWS*COLS*2-1:0] board;
   logic [RW-1:0] row;
   logic [2:0] drop_col;
   logic [1:0] dir;
   logic [PW-1:0] pieces;
   logic right_p, left_p, drop_p;
   int dr, dc, run, r, c;
   logic stop, win;
   btn_edge u_right (.clk(clk), .rst(rst), .level(move_right), .press(right_p));
   btn_edge u_left  (.clk(clk), .rst(rst), .level(move_left),  .press(left_p));
   btn_edge u_drop  (.clk(clk), .rst(rst), .level(drop_piece), .press(drop_p));
   // Run length through the placed piece along the direction selected by dir, capped at 3 per side.
   always_comb begin
      r = 0;
      c = 0;
      stop = 1'b0;
      dr = (dir == 2'd0) ? 0 : 1;
      dc = (dir == 2'd1) ? 0 : (dir == 2'd3) ? -1 : 1;
      run = 1;
      for (int s = -1; s <= 1; s += 2) begin
         stop = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            r = int'(row) + s * dr * k;
            c = int'(drop_col) + s * dc * k;
            if (!stop && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                board[cell_idx(r, c, COLS) +: 2] == current_player)
               run++;
            else
               stop = 1'b1;
         end
      end
      win = run >= 4;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         board <= '0;
         current_col <= '0;
         current_player <= CELL_P1;
         winner <= WIN_NONE;
         row <= '0;
         drop_col <= '0;
         dir <= '0;
         pieces <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (drop_p) begin
                  drop_col <= current_col;
                  row <= '0;
                  state <= DROP;
               end else if (right_p && !left_p && current_col != 3'(COLS - 1))
                  current_col <= current_col + 3'd1;
               else if (left_p && !right_p && current_col != 3'd0)
                  current_col <= current_col - 3'd1;
            end
            DROP: begin
               if (board[cell_idx(int'(row), int'(drop_col), COLS) +: 2] == CELL_EMPTY) begin
                  board[cell_idx(int'(row), int'(drop_col), COLS) +: 2] <= current_player;
                  pieces <= pieces + PW'(1);
                  dir <= '0;
                  state <= CHECK;
               end else if (row == RW'(ROWS - 1))
                  state <= IDLE;
               else
                  row <= row + RW'(1);
            end
            CHECK: begin
               if (win) begin
                  winner <= current_player;
                  state <= OVER;
               end else if (dir == 2'd3) begin
                  if (pieces == PW'(ROWS * COLS)) begin
                     winner <= WIN_DRAW;
                     state <= OVER;
                  end else begin
                     current_player <= (current_player == CELL_P1) ? CELL_P2 : CELL_P1;
                     state <= IDLE;
                  end
               end else
                  dir <= dir + 2'd1;
            end
            OVER: ;
         endcase
      end
   end
   assign board_out = board;
   assign game_over = winner != WIN_NONE;
   assign busy = state == DROP || state == CHECK;
endmodule
